crc_frame_engine: RTL and testbench
===================================

// Module: crc_frame_engine
// PURPOSE
//  Parametrised multi-byte CRC engine with frame awareness: CRC width, polynomial, reflection, init,
//  xor-out and bus width are parameters. Accepts a valid/ready byte stream with SOF/EOF and
//  contiguous byte-keep, and emits one per-frame result (CRC, FCS-check flag, byte length) on a
//  valid/ready result port. Sits after the MAC RX/TX byte aligner. Serves as the generator (TX FCS
//  insert) and as the checker (RX FCS strip).
// PARAMETERS
//  DATA_BYTES  8            bytes per beat, 1..16
//  CRC_WIDTH   32           CRC register width, 8..32
//  POLY        32'h04C11DB7 normal-form polynomial; low CRC_WIDTH bits used
//  INIT        32'hFFFFFFFF register value at SOF
//  REFLECT     1            1: bits LSB-first per byte and result reflected; 0: MSB-first
//  XOROUT      32'hFFFFFFFF xored into register to form o_res_crc
//  RESIDUE     32'hDEBB20E3 raw (pre-XOROUT) register value meaning "FCS good"
// PORTS
//  i_clk        in   1              clock
//  i_reset_n    in   1              asynchronous, active-low reset
//  i_valid      in   1              input beat valid
//  o_ready      out  1              input beat accepted when i_valid & o_ready
//  i_data       in   8*DATA_BYTES   byte k = i_data[8k+:8]; byte 0 is first on the wire
//  i_keep       in   DATA_BYTES     byte enables, contiguous from bit 0 (thermometer)
//  i_sof        in   1              first beat of frame
//  i_eof        in   1              last beat of frame
//  o_res_valid  out  1              result valid
//  i_res_ready  in   1              result consumed when o_res_valid & i_res_ready
//  o_res_crc    out  CRC_WIDTH      final CRC = raw ^ XOROUT
//  o_res_ok     out  1              raw register == RESIDUE
//  o_res_len    out  16             frame byte count, saturates at 16'hFFFF
//  o_err_abort  out  1              1-cycle pulse: frame restarted or dropped (see below)
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled outside): state IDLE, crc=INIT, len=0,
//    o_res_valid=0, o_res_crc=0, o_res_ok=0, o_res_len=0, o_err_abort=0.
//  - o_ready = !o_res_valid | i_res_ready (combinational). Input is never accepted while a result
//    is pending and not being taken.
//  - FSM:
//    - IDLE: accepted beat with i_sof -> process it. If !i_eof -> ACCUM. Accepted beat without
//      i_sof -> dropped, o_err_abort pulses.
//    - ACCUM: accepted beat without i_sof -> processed; i_eof -> IDLE. Accepted beat with i_sof ->
//      current frame discarded (no result), new frame started from INIT, o_err_abort pulses.
//  - Per beat: process bytes 0..n-1 in order, n = popcount(i_keep), in one cycle; no lookup
//    tables, unrolled XOR network. Non-thermometer keep: bytes up to the first zero only.
//  - keep=0 beats are legal: CRC and len are unchanged, and i_sof/i_eof still take effect.
//    The empty frame (SOF&EOF, keep=0) gives crc = INIT^XOROUT.
//  - Latency: result registered. o_res_valid rises the cycle after the EOF beat is accepted and
//    holds, together with crc/ok/len, until consumed. A new frame's SOF beat may be accepted in
//    the same cycle the result is consumed (full throughput, 1 result per EOF).
//  - len: 16-bit, += n per beat, saturates at 16'hFFFF. Reset to 0 at each SOF.
//  - SOF&EOF in the same beat: a single-beat frame.
//  - Reset mid-frame or with a result pending: the frame and the result are lost, and no abort
//    pulse is issued.
//  - CRC_WIDTH<32: POLY/INIT/XOROUT/RESIDUE are truncated to their low CRC_WIDTH bits.
// TESTING
//  - Defaults, "123456789": beat0 = "12345678" (keep FF, sof), beat1 = "9" (keep 01, eof)
//    -> o_res_crc=32'hCBF43926, o_res_len=9, one cycle after beat1.
//  - Same 9 bytes followed by 26 39 F4 CB in one frame -> o_res_ok=1, len=13.
//    Corrupt any one bit -> o_res_ok=0.
//  - Empty frame: sof&eof, keep=00 -> crc=32'h00000000, len=0.
//  - Backpressure: hold i_res_ready=0 for 5 cycles after a result -> o_ready=0 and result stable
//    throughout. On release, the next SOF is accepted in the same cycle.
//  - Abort: mid-frame SOF -> o_err_abort pulses once, no result for the old frame, and the new
//    frame's CRC is correct. A beat without sof in IDLE -> dropped plus a pulse.
//  - CRC_WIDTH=16, POLY=16'h1021, INIT=16'hFFFF, REFLECT=0, XOROUT=0, DATA_BYTES=3,
//    "123456789" -> 16'h29B1. Assert i_reset_n mid-frame -> outputs return to reset values.

Source files
------------

// File: rtl/crc_frame_engine_if.sv
// Byte-stream input and per-frame result bundle for crc_frame_engine.
// Latency: none (wires only).
// Backpressure: carries o_ready on the stream side and i_res_ready on the result side.
//
// Ports (slave = engine side):
//   stream : i_valid/o_ready handshake, i_data, i_keep, i_sof, i_eof
//   result : o_res_valid/i_res_ready handshake, o_res_crc, o_res_ok, o_res_len
//   status : o_err_abort single-cycle pulse
interface crc_frame_engine_if #(
   parameter int DATA_BYTES = 8,
   parameter int CRC_WIDTH  = 32
) ();
   logic                    i_valid;
   logic                    o_ready;
   logic [8*DATA_BYTES-1:0] i_data;
   logic [DATA_BYTES-1:0]   i_keep;
   logic                    i_sof;
   logic                    i_eof;
   logic                    o_res_valid;
   logic                    i_res_ready;
   logic [CRC_WIDTH-1:0]    o_res_crc;
   logic                    o_res_ok;
   logic [15:0]             o_res_len;
   logic                    o_err_abort;

   modport slave (
      input  i_valid, i_data, i_keep, i_sof, i_eof, i_res_ready,
      output o_ready, o_res_valid, o_res_crc, o_res_ok, o_res_len, o_err_abort
   );

   modport master (
      output i_valid, i_data, i_keep, i_sof, i_eof, i_res_ready,
      input  o_ready, o_res_valid, o_res_crc, o_res_ok, o_res_len, o_err_abort
   );
endinterface

// File: rtl/crc_frame_engine.sv
// Frame-aware multi-byte CRC generator/checker producing one (crc, ok, len) result per frame.
// Latency: result registered, o_res_valid rises one cycle after the EOF beat is accepted.
// Backpressure: o_ready drops only while a result is pending and not being consumed.
//
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   bus (slave)      : byte stream in (valid/ready, data, keep, sof, eof),
//                      result out (valid/ready, crc, ok, len), abort pulse
module crc_frame_engine #(
   parameter int          DATA_BYTES = 8,
   parameter int          CRC_WIDTH  = 32,
   parameter logic [31:0] POLY       = 32'h04C11DB7,
   parameter logic [31:0] INIT       = 32'hFFFFFFFF,
   parameter bit          REFLECT    = 1'b1,
   parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
   parameter logic [31:0] RESIDUE    = 32'hDEBB20E3
) (
   input logic               i_clk,
   input logic               i_reset_n,
   crc_frame_engine_if.slave bus
);
   localparam int            CW        = CRC_WIDTH;
   localparam int            KW        = $clog2(DATA_BYTES + 1);
   localparam logic [CW-1:0] POLY_T    = POLY[CW-1:0];
   localparam logic [CW-1:0] INIT_T    = INIT[CW-1:0];
   localparam logic [CW-1:0] XOROUT_T  = XOROUT[CW-1:0];
   localparam logic [CW-1:0] RESIDUE_T = RESIDUE[CW-1:0];

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   state_t state, state_nxt;

   // running frame state
   logic [CW-1:0] crc_q;
   logic [15:0]   len_q;

   // registered outputs
   logic          res_valid_q;
   logic [CW-1:0] res_crc_q;
   logic          res_ok_q;
   logic [15:0]   res_len_q;
   logic          abort_q;

   // control decoded from the accepted beat
   logic accept;
   logic process;   // beat contributes to a frame
   logic start;     // beat opens a frame: crc/len restart from INIT/0
   logic finish;    // beat closes a frame: load result
   logic abort_nxt;

   // datapath
   logic [DATA_BYTES-1:0] byte_en;
   logic                  keep_run;
   logic [KW-1:0]         nbytes;
   logic [CW-1:0]         crc_base, crc_calc, crc_raw;
   logic                  crc_fb, crc_din;
   logic [15:0]           len_base, len_calc;
   logic [16:0]           len_sum;

   function automatic logic [CW-1:0] reflect_bits(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < CW; i++) r[i] = v[CW-1-i];
      return r;
   endfunction

   assign bus.o_ready = !res_valid_q || bus.i_res_ready;
   assign accept      = bus.i_valid && bus.o_ready;

   // Only the leading run of keep bits counts; anything after the first hole is ignored.
   always_comb begin
      byte_en  = '0;
      nbytes   = '0;
      keep_run = 1'b1;
      for (int k = 0; k < DATA_BYTES; k++) begin
         if (keep_run && bus.i_keep[k]) begin
            byte_en[k] = 1'b1;
            nbytes     = nbytes + KW'(1);
         end else begin
            keep_run = 1'b0;
         end
      end
   end

   // FSM next-state and beat decode
   always_comb begin
      state_nxt = state;
      process   = 1'b0;
      start     = 1'b0;
      finish    = 1'b0;
      abort_nxt = 1'b0;
      if (accept) begin
         if (bus.i_sof) begin
            // an SOF inside an open frame throws that frame away
            process   = 1'b1;
            start     = 1'b1;
            finish    = bus.i_eof;
            abort_nxt = (state == S_ACCUM);
            state_nxt = bus.i_eof ? S_IDLE : S_ACCUM;
         end else if (state == S_ACCUM) begin
            process = 1'b1;
            finish  = bus.i_eof;
            if (bus.i_eof) state_nxt = S_IDLE;
         end else begin
            // stray beat outside a frame: dropped
            abort_nxt = 1'b1;
         end
      end
   end

   // Bit-serial CRC unrolled across all enabled bytes. The register is kept in normal
   // (MSB-first) form; reflection only changes the bit feed order and the final readout.
   always_comb begin
      crc_base = start ? INIT_T : crc_q;
      crc_calc = crc_base;
      crc_fb   = 1'b0;
      crc_din  = 1'b0;
      for (int k = 0; k < DATA_BYTES; k++) begin
         for (int j = 0; j < 8; j++) begin
            if (byte_en[k]) begin
               crc_din  = REFLECT ? bus.i_data[8*k+j] : bus.i_data[8*k+7-j];
               crc_fb   = crc_calc[CW-1] ^ crc_din;
               crc_calc = {crc_calc[CW-2:0], 1'b0} ^ (crc_fb ? POLY_T : '0);
            end
         end
      end
      crc_raw = REFLECT ? reflect_bits(crc_calc) : crc_calc;
   end

   always_comb begin
      len_base = start ? 16'd0 : len_q;
      len_sum  = {1'b0, len_base} + 17'(nbytes);
      len_calc = len_sum[16] ? 16'hFFFF : len_sum[15:0];
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         crc_q       <= INIT_T;
         len_q       <= '0;
         res_valid_q <= 1'b0;
         res_crc_q   <= '0;
         res_ok_q    <= 1'b0;
         res_len_q   <= '0;
         abort_q     <= 1'b0;
      end else begin
         abort_q <= abort_nxt;
         if (process) begin
            crc_q <= finish ? INIT_T : crc_calc;
            len_q <= finish ? 16'd0 : len_calc;
         end
         // loading a new result takes priority over the consume of the old one
         if (finish) begin
            res_valid_q <= 1'b1;
            res_crc_q   <= crc_raw ^ XOROUT_T;
            res_ok_q    <= (crc_raw == RESIDUE_T);
            res_len_q   <= len_calc;
         end else if (bus.i_res_ready) begin
            res_valid_q <= 1'b0;
         end
      end
   end

   assign bus.o_res_valid = res_valid_q;
   assign bus.o_res_crc   = res_crc_q;
   assign bus.o_res_ok    = res_ok_q;
   assign bus.o_res_len   = res_len_q;
   assign bus.o_err_abort = abort_q;
endmodule

// File: tb/tb_crc_frame_engine.sv
// Bench for crc_frame_engine: default CRC-32 build (8-byte bus) and a CRC-16/CCITT-FALSE build (3-byte bus).
// Expected results are pushed to per-DUT queues as frames are sent and popped on each result handshake.
module tb_crc_frame_engine;
   typedef struct packed {
      logic [31:0] crc;
      logic        ok;
      logic [15:0] len;
   } exp_t;

   logic clk;
   logic rst_a_n, rst_b_n;
   int   checks = 0;
   int   errors = 0;
   int   abort_cnt_a = 0;
   int   abort_cnt_b = 0;
   int   last_wait_a = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic [7:0] fbuf[$];

   crc_frame_engine_if #(.DATA_BYTES(8), .CRC_WIDTH(32)) if_a ();
   crc_frame_engine_if #(.DATA_BYTES(3), .CRC_WIDTH(16)) if_b ();

   crc_frame_engine u_a (
      .i_clk     (clk),
      .i_reset_n (rst_a_n),
      .bus       (if_a)
   );

   crc_frame_engine #(
      .DATA_BYTES (3),
      .CRC_WIDTH  (16),
      .POLY       (32'h00001021),
      .INIT       (32'h0000FFFF),
      .REFLECT    (1'b0),
      .XOROUT     (32'h00000000)
   ) u_b (
      .i_clk     (clk),
      .i_reset_n (rst_b_n),
      .bus       (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference models (reflected right-shift CRC-32, MSB-first CRC-16) -------------
   function automatic exp_t model_a();
      exp_t e;
      logic [31:0] r;
      r = 32'hFFFFFFFF;
      foreach (fbuf[i]) begin
         r = r ^ {24'h0, fbuf[i]};
         for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      e.crc = r ^ 32'hFFFFFFFF;
      e.ok  = (r == 32'hDEBB20E3);
      e.len = (fbuf.size() > 65535) ? 16'hFFFF : 16'(fbuf.size());
      return e;
   endfunction

   function automatic exp_t model_b();
      exp_t e;
      logic [15:0] r;
      r = 16'hFFFF;
      foreach (fbuf[i]) begin
         r = r ^ {fbuf[i], 8'h00};
         for (int b = 0; b < 8; b++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      end
      e.crc = {16'h0, r};
      e.ok  = (r == 16'h20E3);
      e.len = 16'(fbuf.size());
      return e;
   endfunction

   // ---------------- scoreboards ----------------
   always @(negedge clk) begin
      exp_t e;
      if (if_a.o_res_valid === 1'b1 && if_a.i_res_ready === 1'b1) begin
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL res_a_unexpected: got crc=%h len=%0d, required no result", if_a.o_res_crc, if_a.o_res_len);
         end else begin
            e = qa.pop_front();
            if (if_a.o_res_crc !== e.crc || if_a.o_res_ok !== e.ok || if_a.o_res_len !== e.len) begin
               errors++;
               $display("FAIL res_a: got crc=%h ok=%b len=%0d, required crc=%h ok=%b len=%0d",
                        if_a.o_res_crc, if_a.o_res_ok, if_a.o_res_len, e.crc, e.ok, e.len);
            end
         end
      end
      if (if_a.o_err_abort === 1'b1) abort_cnt_a++;
   end

   always @(negedge clk) begin
      exp_t e;
      if (if_b.o_res_valid === 1'b1 && if_b.i_res_ready === 1'b1) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL res_b_unexpected: got crc=%h len=%0d, required no result", if_b.o_res_crc, if_b.o_res_len);
         end else begin
            e = qb.pop_front();
            if (if_b.o_res_crc !== e.crc[15:0] || if_b.o_res_ok !== e.ok || if_b.o_res_len !== e.len) begin
               errors++;
               $display("FAIL res_b: got crc=%h ok=%b len=%0d, required crc=%h ok=%b len=%0d",
                        if_b.o_res_crc, if_b.o_res_ok, if_b.o_res_len, e.crc[15:0], e.ok, e.len);
            end
         end
      end
      if (if_b.o_err_abort === 1'b1) abort_cnt_b++;
   end

   // ---------------- drivers (called at posedge+1, return at posedge+1 after acceptance) -----------
   task automatic send_a(input logic [63:0] d, input logic [7:0] k, input logic s, input logic e);
      int w;
      if_a.i_valid = 1'b1; if_a.i_data = d; if_a.i_keep = k; if_a.i_sof = s; if_a.i_eof = e;
      w = 0;
      @(negedge clk);
      while (if_a.o_ready !== 1'b1 && w < 50) begin w++; @(negedge clk); end
      last_wait_a = w;
      if (w >= 50) begin
         checks++; errors++;
         $display("FAIL send_a_timeout: o_ready=%b after %0d cycles, required 1", if_a.o_ready, w);
      end
      @(posedge clk); #1;
      if_a.i_valid = 1'b0;
   endtask

   task automatic send_b(input logic [23:0] d, input logic [2:0] k, input logic s, input logic e);
      int w;
      if_b.i_valid = 1'b1; if_b.i_data = d; if_b.i_keep = k; if_b.i_sof = s; if_b.i_eof = e;
      w = 0;
      @(negedge clk);
      while (if_b.o_ready !== 1'b1 && w < 50) begin w++; @(negedge clk); end
      if (w >= 50) begin
         checks++; errors++;
         $display("FAIL send_b_timeout: o_ready=%b after %0d cycles, required 1", if_b.o_ready, w);
      end
      @(posedge clk); #1;
      if_b.i_valid = 1'b0;
   endtask

   task automatic send_frame_a();
      int idx;
      int nb;
      logic [63:0] d;
      logic [7:0]  k;
      logic        s;
      idx = 0; nb = fbuf.size(); s = 1'b1;
      qa.push_back(model_a());
      if (nb == 0) begin
         send_a('0, '0, 1'b1, 1'b1);
         return;
      end
      while (idx < nb) begin
         d = '0; k = '0;
         for (int j = 0; j < 8; j++)
            if (idx + j < nb) begin d[8*j+:8] = fbuf[idx+j]; k[j] = 1'b1; end
         idx += 8;
         send_a(d, k, s, idx >= nb);
         s = 1'b0;
      end
   endtask

   task automatic send_frame_b(input bit push);
      int idx;
      int nb;
      logic [23:0] d;
      logic [2:0]  k;
      logic        s;
      idx = 0; nb = fbuf.size(); s = 1'b1;
      if (push) qb.push_back(model_b());
      while (idx < nb) begin
         d = '0; k = '0;
         for (int j = 0; j < 3; j++)
            if (idx + j < nb) begin d[8*j+:8] = fbuf[idx+j]; k[j] = 1'b1; end
         idx += 3;
         send_b(d, k, s, idx >= nb);
         s = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while ((qa.size() != 0 || qb.size() != 0) && w < 100) begin w++; @(negedge clk); end
      if (w >= 100) begin
         checks++; errors++;
         $display("FAIL drain_timeout: pending a=%0d b=%0d, required 0", qa.size(), qb.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic load_123456789();
      string s;
      s = "123456789";
      fbuf.delete();
      for (int i = 0; i < s.len(); i++) fbuf.push_back(s[i]);
   endtask

   task automatic load_random(input int n);
      fbuf.delete();
      for (int i = 0; i < n; i++) fbuf.push_back(8'($urandom));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      if_a.i_valid = 0; if_a.i_data = '0; if_a.i_keep = '0; if_a.i_sof = 0; if_a.i_eof = 0; if_a.i_res_ready = 1;
      if_b.i_valid = 0; if_b.i_data = '0; if_b.i_keep = '0; if_b.i_sof = 0; if_b.i_eof = 0; if_b.i_res_ready = 1;
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({if_a.o_res_valid, if_a.o_res_ok, if_a.o_err_abort, if_a.o_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_a_flags: valid/ok/abort/ready=%b%b%b%b, required 0001",
                  if_a.o_res_valid, if_a.o_res_ok, if_a.o_err_abort, if_a.o_ready);
      end
      checks++;
      if (if_a.o_res_crc !== 32'h0 || if_a.o_res_len !== 16'h0) begin
         errors++;
         $display("FAIL reset_a_data: crc=%h len=%h, required 0 0", if_a.o_res_crc, if_a.o_res_len);
      end
      checks++;
      if ({if_b.o_res_valid, if_b.o_res_ok, if_b.o_err_abort, if_b.o_ready} !== 4'b0001 ||
          if_b.o_res_crc !== 16'h0 || if_b.o_res_len !== 16'h0) begin
         errors++;
         $display("FAIL reset_b: valid=%b ok=%b abort=%b ready=%b crc=%h len=%h, required 0 0 0 1 0 0",
                  if_b.o_res_valid, if_b.o_res_ok, if_b.o_err_abort, if_b.o_ready, if_b.o_res_crc, if_b.o_res_len);
      end
      @(posedge clk); #1;
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_known_vector();
      exp_t e;
      e.crc = 32'hCBF43926; e.ok = 1'b0; e.len = 16'd9;
      qa.push_back(e);
      send_a(64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
      checks++;
      if (if_a.o_res_valid !== 1'b0) begin
         errors++;
         $display("FAIL known_early_valid: o_res_valid=%b, required 0", if_a.o_res_valid);
      end
      send_a(64'h39, 8'h01, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (if_a.o_res_valid !== 1'b1 || if_a.o_res_crc !== 32'hCBF43926 || if_a.o_res_len !== 16'd9) begin
         errors++;
         $display("FAIL known_latency: valid=%b crc=%h len=%0d one cycle after eof, required 1 cbf43926 9",
                  if_a.o_res_valid, if_a.o_res_crc, if_a.o_res_len);
      end
      wait_drain();
   endtask

   task automatic test_residue();
      load_123456789();
      fbuf.push_back(8'h26); fbuf.push_back(8'h39); fbuf.push_back(8'hF4); fbuf.push_back(8'hCB);
      send_frame_a();
      fbuf[5] = fbuf[5] ^ 8'h08;
      send_frame_a();
      wait_drain();
   endtask

   task automatic test_empty_and_keep();
      logic [63:0] d0, d1, d2;
      fbuf.delete();
      send_frame_a();
      d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
      fbuf.delete();
      for (int j = 0; j < 8; j++) fbuf.push_back(d0[8*j+:8]);
      for (int j = 0; j < 3; j++) fbuf.push_back(d1[8*j+:8]);
      for (int j = 0; j < 2; j++) fbuf.push_back(d2[8*j+:8]);
      qa.push_back(model_a());
      send_a(d0, 8'hFF, 1'b1, 1'b0);
      send_a({$urandom, $urandom}, 8'h00, 1'b0, 1'b0);
      send_a(d1, 8'b1101_0111, 1'b0, 1'b0);
      send_a(d2, 8'b0000_0011, 1'b0, 1'b1);
      wait_drain();
   endtask

   task automatic test_backpressure();
      exp_t e;
      int w;
      if_a.i_res_ready = 1'b0;
      load_random(20);
      e = model_a();
      send_frame_a();
      w = 0;
      @(negedge clk);
      while (if_a.o_res_valid !== 1'b1 && w < 10) begin w++; @(negedge clk); end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (if_a.o_ready !== 1'b0 || if_a.o_res_valid !== 1'b1 || if_a.o_res_crc !== e.crc || if_a.o_res_len !== e.len) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: ready=%b valid=%b crc=%h len=%0d, required 0 1 %h %0d",
                     c, if_a.o_ready, if_a.o_res_valid, if_a.o_res_crc, if_a.o_res_len, e.crc, e.len);
         end
         if (c < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      if_a.i_res_ready = 1'b1;
      load_random(6);
      send_frame_a();
      checks++;
      if (last_wait_a != 0) begin
         errors++;
         $display("FAIL backpressure_release: sof accepted after %0d extra cycles, required 0", last_wait_a);
      end
      wait_drain();
   endtask

   task automatic test_abort();
      int base;
      base = abort_cnt_a;
      send_a({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0);
      load_random(11);
      send_frame_a();
      wait_drain();
      checks++;
      if (abort_cnt_a != base + 1) begin
         errors++;
         $display("FAIL abort_restart: pulses=%0d, required %0d", abort_cnt_a - base, 1);
      end
      send_a({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (abort_cnt_a != base + 2 || if_a.o_res_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_drop: pulses=%0d valid=%b, required 2 0", abort_cnt_a - base, if_a.o_res_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int base;
      base = abort_cnt_a;
      for (int f = 0; f < 6; f++) begin
         load_random($urandom_range(1, 30));
         send_frame_a();
      end
      wait_drain();
      checks++;
      if (abort_cnt_a != base) begin
         errors++;
         $display("FAIL back_to_back_abort: pulses=%0d, required 0", abort_cnt_a - base);
      end
   endtask

   task automatic test_len_saturation();
      load_random(65600);
      send_frame_a();
      wait_drain();
   endtask

   task automatic test_crc16();
      exp_t e;
      load_123456789();
      e.crc = 32'h000029B1; e.ok = 1'b0; e.len = 16'd9;
      qb.push_back(e);
      send_frame_b(1'b0);
      for (int f = 0; f < 4; f++) begin
         load_random($urandom_range(1, 14));
         send_frame_b(1'b1);
      end
      wait_drain();
   endtask

   task automatic test_reset_midframe();
      exp_t e;
      int base;
      base = abort_cnt_b;
      if_b.i_res_ready = 1'b0;
      load_random(5);
      send_frame_b(1'b0);
      @(negedge clk);
      checks++;
      if (if_b.o_res_valid !== 1'b1 || if_b.o_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_pending_setup: valid=%b ready=%b, required 1 0", if_b.o_res_valid, if_b.o_ready);
      end
      @(posedge clk); #1;
      rst_b_n = 1'b0;
      #1;
      checks++;
      if (if_b.o_res_valid !== 1'b0 || if_b.o_res_crc !== 16'h0 || if_b.o_res_ok !== 1'b0 ||
          if_b.o_res_len !== 16'h0 || if_b.o_err_abort !== 1'b0 || if_b.o_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_pending: valid=%b crc=%h ok=%b len=%h abort=%b ready=%b, required 0 0 0 0 0 1",
                  if_b.o_res_valid, if_b.o_res_crc, if_b.o_res_ok, if_b.o_res_len, if_b.o_err_abort, if_b.o_ready);
      end
      @(posedge clk); #1;
      rst_b_n = 1'b1;
      if_b.i_res_ready = 1'b1;
      send_b(24'h333231, 3'b111, 1'b1, 1'b0);
      rst_b_n = 1'b0;
      #1;
      checks++;
      if (if_b.o_res_valid !== 1'b0 || if_b.o_res_len !== 16'h0 || if_b.o_err_abort !== 1'b0) begin
         errors++;
         $display("FAIL reset_midframe: valid=%b len=%h abort=%b, required 0 0 0",
                  if_b.o_res_valid, if_b.o_res_len, if_b.o_err_abort);
      end
      @(posedge clk); #1;
      rst_b_n = 1'b1;
      @(posedge clk); #1;
      // state must be back in IDLE: a continuation beat is dropped
      send_b(24'h363534, 3'b111, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (abort_cnt_b != base + 1 || if_b.o_res_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state_idle: pulses=%0d valid=%b, required 1 0", abort_cnt_b - base, if_b.o_res_valid);
      end
      @(posedge clk); #1;
      load_123456789();
      e.crc = 32'h000029B1; e.ok = 1'b0; e.len = 16'd9;
      qb.push_back(e);
      send_frame_b(1'b0);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_known_vector();
      test_residue();
      test_empty_and_keep();
      test_backpressure();
      test_abort();
      test_back_to_back();
      test_len_saturation();
      test_crc16();
      test_reset_midframe();
      repeat (3) @(negedge clk);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL leftover_results: pending a=%0d b=%0d, required 0 0", qa.size(), qb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
